// File: rtl/camera_frame_capture.sv
// rtl/camera_frame_capture.sv - camera sensor capture into frame RAM with decimation and windowing
module camera_frame_capture #(
    parameter int CLK_DIV         = 5,
    parameter int DATA_W          = 8,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int FRAME_W         = 160,
    parameter int FRAME_H         = 120,
    parameter int DECIM           = 4,
    parameter int ADDR_W          = 15
) (
    input  logic                                i_Clk,
    input  logic                                i_Rst_n,
    input  logic                                i_EnableCameraRead,
    input  logic                                i_Single,
    input  logic                                i_PLK,
    input  logic                                i_VS,
    input  logic                                i_HS,
    input  logic [DATA_W-1:0]                   i_D,
    output logic                                o_XLK,
    output logic [DATA_W*BYTES_PER_PIXEL-1:0]   o_to_RAM,
    output logic [ADDR_W-1:0]                   o_RAM_Adress,
    output logic                                o_RAM_Write_Enable,
    output logic                                o_Frame_Done,
    output logic                                o_Busy,
    output logic                                o_Overflow
);

    localparam int PIX_W = DATA_W * BYTES_PER_PIXEL;
    localparam int XC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int CW    = $clog2(FRAME_W + 1);
    localparam int RW    = $clog2(FRAME_H + 1);
    localparam int AW1   = ADDR_W + 1;

    localparam logic [XC_W-1:0] XC_LAST   = XC_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(DECIM - 1);
    localparam logic            BP_LAST   = 1'(BYTES_PER_PIXEL - 1);
    localparam logic [AW1-1:0]  LAST_ADDR = AW1'(FRAME_W * FRAME_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS_LOW,
        ST_CAPTURE
    } state_t;

    state_t state_q, state_d;

    logic [XC_W-1:0]   xclk_cnt;
    logic [2:0]        plk_s, vs_s, hs_s;
    logic [DATA_W-1:0] d_s1, d_s2;
    logic              single_q;
    logic              byte_ph;
    logic [PIX_W-1:0]  pix_asm;
    logic [PIX_W-1:0]  asm_next;
    logic [PH_W-1:0]   col_ph, row_ph;
    logic [CW-1:0]     col_out;
    logic [RW-1:0]     row_out;
    logic [AW1-1:0]    row_base;
    logic [AW1-1:0]    wr_addr;
    logic              keep;

    logic plk_rise, vs_rise, vs_fall, hs_fall, hs_on;
    logic arm, start_frame, frame_end, cap_active;

    assign plk_rise = plk_s[1] & ~plk_s[2];
    assign vs_rise  = vs_s[1] & ~vs_s[2];
    assign vs_fall  = ~vs_s[1] & vs_s[2];
    assign hs_fall  = ~hs_s[1] & hs_s[2];
    assign hs_on    = hs_s[1];

    // First byte of a pixel ends up in the MSBs as later bytes shift in below it.
    assign asm_next = (pix_asm << DATA_W) | PIX_W'(d_s2);
    // Address is built from a per-row base plus the output column, so short lines stay aligned.
    assign wr_addr  = row_base + AW1'(col_out);
    assign keep     = (col_ph == '0) && (row_ph == '0) &&
                      (col_out < CW'(FRAME_W)) && (row_out < RW'(FRAME_H));
    assign o_Busy   = (state_q == ST_WAIT_VS_LOW) || (state_q == ST_CAPTURE);

    // Free-running sensor master clock divider.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            xclk_cnt <= '0;
            o_XLK    <= 1'b0;
        end else if (xclk_cnt == XC_LAST) begin
            xclk_cnt <= '0;
            o_XLK    <= ~o_XLK;
        end else begin
            xclk_cnt <= xclk_cnt + 1'b1;
        end
    end

    // Two-flop synchronisers plus a third stage for edge detection; data tracks PLK depth.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            plk_s <= '0;
            vs_s  <= '0;
            hs_s  <= '0;
            d_s1  <= '0;
            d_s2  <= '0;
        end else begin
            plk_s <= {plk_s[1:0], i_PLK};
            vs_s  <= {vs_s[1:0], i_VS};
            hs_s  <= {hs_s[1:0], i_HS};
            d_s1  <= i_D;
            d_s2  <= d_s1;
        end
    end

    // FSM state register.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control; dropping enable always wins over frame events.
    always_comb begin
        state_d     = state_q;
        arm         = 1'b0;
        start_frame = 1'b0;
        frame_end   = 1'b0;
        cap_active  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_EnableCameraRead) begin
                    arm     = 1'b1;
                    state_d = ST_WAIT_VS_LOW;
                end
            end
            ST_WAIT_VS_LOW: begin
                if (!i_EnableCameraRead) begin
                    state_d = ST_IDLE;
                end else if (vs_fall) begin
                    start_frame = 1'b1;
                    state_d     = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!i_EnableCameraRead) begin
                    state_d = ST_IDLE;
                end else if (vs_rise) begin
                    frame_end = 1'b1;
                    state_d   = single_q ? ST_IDLE : ST_WAIT_VS_LOW;
                end else begin
                    cap_active = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pixel assembly, decimation counters, window check and RAM write strobe.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            single_q           <= 1'b0;
            byte_ph            <= 1'b0;
            pix_asm            <= '0;
            col_ph             <= '0;
            row_ph             <= '0;
            col_out            <= '0;
            row_out            <= '0;
            row_base           <= '0;
            o_to_RAM           <= '0;
            o_RAM_Adress       <= '0;
            o_RAM_Write_Enable <= 1'b0;
            o_Frame_Done       <= 1'b0;
            o_Overflow         <= 1'b0;
        end else begin
            o_RAM_Write_Enable <= 1'b0;
            o_Frame_Done       <= frame_end;
            if (arm) begin
                single_q   <= i_Single;
                o_Overflow <= 1'b0;
            end
            if (start_frame) begin
                byte_ph  <= 1'b0;
                col_ph   <= '0;
                row_ph   <= '0;
                col_out  <= '0;
                row_out  <= '0;
                row_base <= '0;
            end else if (cap_active) begin
                if (hs_fall) begin
                    byte_ph <= 1'b0;
                    col_ph  <= '0;
                    col_out <= '0;
                    if (row_ph == PH_LAST) begin
                        row_ph <= '0;
                        if (row_out < RW'(FRAME_H)) begin
                            row_out  <= row_out + 1'b1;
                            row_base <= row_base + AW1'(FRAME_W);
                        end
                    end else begin
                        row_ph <= row_ph + 1'b1;
                    end
                end else if (plk_rise && hs_on) begin
                    pix_asm <= asm_next;
                    if (byte_ph == BP_LAST) begin
                        byte_ph <= 1'b0;
                        if (col_ph == PH_LAST) begin
                            col_ph <= '0;
                            if (col_out < CW'(FRAME_W)) begin
                                col_out <= col_out + 1'b1;
                            end
                        end else begin
                            col_ph <= col_ph + 1'b1;
                        end
                        if (keep) begin
                            if (wr_addr > LAST_ADDR) begin
                                o_Overflow <= 1'b1;
                            end else begin
                                o_RAM_Write_Enable <= 1'b1;
                                o_to_RAM           <= asm_next;
                                o_RAM_Adress       <= wr_addr[ADDR_W-1:0];
                            end
                        end
                    end else begin
                        byte_ph <= byte_ph + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_camera_frame_capture.sv
// tb/tb_camera_frame_capture.sv - scoreboard bench for camera_frame_capture
module tb_camera_frame_capture;

    localparam int FW_A = 4, FH_A = 2, D_A = 1;
    localparam int FW_B = 2, FH_B = 2, D_B = 2;
    localparam logic [31:0] SENTINEL = 32'hDEAD_0000;

    logic       i_Clk = 1'b0;
    logic       i_Rst_n, i_EnableCameraRead, i_Single, i_PLK, i_VS, i_HS;
    logic [7:0] i_D;

    logic        a_xlk, a_we, a_done, a_busy, a_ovf;
    logic [15:0] a_data;
    logic [3:0]  a_addr;
    logic        b_xlk, b_we, b_done, b_busy, b_ovf;
    logic [15:0] b_data;
    logic [2:0]  b_addr;

    camera_frame_capture #(.CLK_DIV(5), .DATA_W(8), .BYTES_PER_PIXEL(2), .FRAME_W(FW_A),
                           .FRAME_H(FH_A), .DECIM(D_A), .ADDR_W(4)) dut_a (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_EnableCameraRead(i_EnableCameraRead),
        .i_Single(i_Single), .i_PLK(i_PLK), .i_VS(i_VS), .i_HS(i_HS), .i_D(i_D),
        .o_XLK(a_xlk), .o_to_RAM(a_data), .o_RAM_Adress(a_addr), .o_RAM_Write_Enable(a_we),
        .o_Frame_Done(a_done), .o_Busy(a_busy), .o_Overflow(a_ovf)
    );

    camera_frame_capture #(.CLK_DIV(3), .DATA_W(8), .BYTES_PER_PIXEL(2), .FRAME_W(FW_B),
                           .FRAME_H(FH_B), .DECIM(D_B), .ADDR_W(3)) dut_b (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_EnableCameraRead(i_EnableCameraRead),
        .i_Single(i_Single), .i_PLK(i_PLK), .i_VS(i_VS), .i_HS(i_HS), .i_D(i_D),
        .o_XLK(b_xlk), .o_to_RAM(b_data), .o_RAM_Adress(b_addr), .o_RAM_Write_Enable(b_we),
        .o_Frame_Done(b_done), .o_Busy(b_busy), .o_Overflow(b_ovf)
    );

    always #5 i_Clk = ~i_Clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, last_rise = 0;
    int done_a = 0, done_b = 0;
    logic busy_done_a = 1'b0;
    logic xa_prev = 1'b0, xb_prev = 1'b0;
    int rise_a = 0, rise_b = 0, per_a = 0, per_b = 0;

    logic [31:0] q_a[$], q_b[$];

    logic        m_cap = 1'b0;
    int          m_row = 0, m_col = 0, m_phase = 0;
    logic [15:0] m_pix = '0;
    logic [7:0]  byte_val = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge i_Clk) cyc++;

    // Scoreboard pop, frame-done counting and XLK period tracking.
    always @(negedge i_Clk) begin
        logic [31:0] e;
        if (a_we === 1'b1) begin
            e = (q_a.size() > 0) ? q_a.pop_front() : SENTINEL;
            chk("a_wr", {12'h0, a_addr, a_data}, e);
            chk("a_latency", cyc - last_rise, 3);
        end
        if (b_we === 1'b1) begin
            e = (q_b.size() > 0) ? q_b.pop_front() : SENTINEL;
            chk("b_wr", {13'h0, b_addr, b_data}, e);
        end
        if (a_done === 1'b1) begin
            done_a++;
            busy_done_a = a_busy;
        end
        if (b_done === 1'b1) done_b++;
        if (a_xlk && !xa_prev) begin per_a = cyc - rise_a; rise_a = cyc; end
        if (b_xlk && !xb_prev) begin per_b = cyc - rise_b; rise_b = cyc; end
        xa_prev = a_xlk;
        xb_prev = b_xlk;
    end

    task automatic model_pixel(input int row, input int col, input logic [15:0] pix);
        if (row % D_A == 0 && col % D_A == 0 && row / D_A < FH_A && col / D_A < FW_A)
            q_a.push_back({16'((row / D_A) * FW_A + col / D_A), pix});
        if (row % D_B == 0 && col % D_B == 0 && row / D_B < FH_B && col / D_B < FW_B)
            q_b.push_back({16'((row / D_B) * FW_B + col / D_B), pix});
    endtask

    task automatic send_byte();
        i_D = byte_val;
        repeat (3) @(negedge i_Clk);
        i_PLK = 1'b1;
        last_rise = cyc;
        if (m_cap) begin
            m_pix = {m_pix[7:0], byte_val};
            if (m_phase == 1) begin
                model_pixel(m_row, m_col, m_pix);
                m_col++;
                m_phase = 0;
            end else begin
                m_phase = 1;
            end
        end
        byte_val++;
        repeat (4) @(negedge i_Clk);
        i_PLK = 1'b0;
        @(negedge i_Clk);
    endtask

    task automatic line_end();
        i_HS = 1'b0;
        m_row++;
        m_col = 0;
        m_phase = 0;
        repeat (6) @(negedge i_Clk);
    endtask

    task automatic send_line(input int nbytes);
        i_HS = 1'b1;
        repeat (2) @(negedge i_Clk);
        for (int i = 0; i < nbytes; i++) send_byte();
        line_end();
    endtask

    task automatic frame_start();
        i_VS = 1'b0;
        m_row = 0;
        m_col = 0;
        m_phase = 0;
        repeat (6) @(negedge i_Clk);
    endtask

    task automatic frame_end();
        i_VS = 1'b1;
        repeat (12) @(negedge i_Clk);
    endtask

    initial begin
        i_Rst_n = 1'b0; i_EnableCameraRead = 1'b0; i_Single = 1'b0;
        i_PLK = 1'b0; i_VS = 1'b1; i_HS = 1'b0; i_D = '0;
        repeat (3) @(negedge i_Clk);
        chk("rst_a_xlk", a_xlk, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_a_we", a_we, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_ovf", a_ovf, 0);
        chk("rst_b_all", {b_xlk, b_data, b_addr, b_we, b_done, b_busy, b_ovf}, 0);
        i_Rst_n = 1'b1;
        @(negedge i_Clk);
        chk("xlk_after_rst", a_xlk, 0);
        repeat (40) @(negedge i_Clk);
        chk("xlk_period_a", per_a, 10);
        chk("xlk_period_b", per_b, 6);

        // single-shot frame, 4 lines of 4 pixels
        i_Single = 1'b1; i_EnableCameraRead = 1'b1;
        repeat (3) @(negedge i_Clk);
        m_cap = 1'b1; byte_val = 8'h00;
        frame_start();
        for (int l = 0; l < 4; l++) send_line(8);
        frame_end();
        chk("single_done_a", done_a, 1);
        chk("single_done_b", done_b, 1);
        chk("single_idle_at_done", busy_done_a, 0);
        chk("single_qa_empty", q_a.size(), 0);
        chk("single_qb_empty", q_b.size(), 0);
        chk("single_ovf_a", a_ovf, 0);
        i_EnableCameraRead = 1'b0; m_cap = 1'b0;
        repeat (4) @(negedge i_Clk);

        // continuous, two frames
        i_Single = 1'b0; i_EnableCameraRead = 1'b1;
        repeat (3) @(negedge i_Clk);
        m_cap = 1'b1;
        for (int f = 0; f < 2; f++) begin
            frame_start();
            for (int l = 0; l < 4; l++) send_line(8);
            frame_end();
        end
        chk("cont_done_a", done_a, 3);
        chk("cont_done_b", done_b, 3);
        chk("cont_busy_at_done", busy_done_a, 1);
        chk("cont_qa_empty", q_a.size(), 0);
        chk("cont_qb_empty", q_b.size(), 0);

        // abort mid-line
        frame_start();
        send_line(8);
        i_HS = 1'b1;
        repeat (2) @(negedge i_Clk);
        send_byte(); send_byte();
        i_EnableCameraRead = 1'b0; m_cap = 1'b0;
        @(negedge i_Clk);
        chk("abort_busy_a", a_busy, 0);
        chk("abort_busy_b", b_busy, 0);
        for (int i = 0; i < 6; i++) send_byte();
        line_end();
        send_line(8); send_line(8);
        frame_end();
        chk("abort_no_done", done_a, 3);
        chk("abort_qa_empty", q_a.size(), 0);
        chk("abort_qb_empty", q_b.size(), 0);
        chk("abort_addr_hold_a", a_addr, 4);
        chk("abort_addr_hold_b", b_addr, 1);

        // reset in the middle of a line
        i_EnableCameraRead = 1'b1;
        repeat (3) @(negedge i_Clk);
        m_cap = 1'b1;
        frame_start();
        send_line(8);
        i_HS = 1'b1;
        repeat (2) @(negedge i_Clk);
        send_byte(); send_byte(); send_byte();
        chk("pre_rst_busy", a_busy, 1);
        chk("pre_rst_addr", a_addr, 4);
        chk("pre_rst_qa_empty", q_a.size(), 0);
        i_Rst_n = 1'b0;
        #1;
        chk("midrst_a_all", {a_xlk, a_data, a_addr, a_we, a_done, a_busy, a_ovf}, 0);
        chk("midrst_b_all", {b_xlk, b_data, b_addr, b_we, b_done, b_busy, b_ovf}, 0);
        m_cap = 1'b0; i_EnableCameraRead = 1'b0; i_HS = 1'b0; i_VS = 1'b1;
        q_a.delete(); q_b.delete();
        repeat (4) @(negedge i_Clk);
        i_Rst_n = 1'b1;
        repeat (4) @(negedge i_Clk);

        // odd-length first line: trailing byte dropped, next line restarts at phase 0
        i_Single = 1'b1; i_EnableCameraRead = 1'b1;
        repeat (3) @(negedge i_Clk);
        m_cap = 1'b1; byte_val = 8'h00;
        frame_start();
        send_line(5);
        for (int l = 0; l < 3; l++) send_line(8);
        frame_end();
        chk("odd_done_a", done_a, 4);
        chk("odd_idle_at_done", busy_done_a, 0);
        chk("odd_qa_empty", q_a.size(), 0);
        chk("odd_qb_empty", q_b.size(), 0);
        chk("odd_ovf_a", a_ovf, 0);
        chk("odd_last_addr_a", a_addr, 7);
        i_EnableCameraRead = 1'b0; m_cap = 1'b0;
        repeat (4) @(negedge i_Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/camera_frame_capture.md
Name: camera_frame_capture

Overview:
- Parametrised successor to the team's single-byte camera reader. Generates the sensor master clock (XCLK) and synchronises the sensor's PCLK/VSYNC/HREF/D bus into i_Clk.
- Assembles 1- or 2-byte pixels and applies integer decimation and a fixed output window. Writes pixels to frame RAM with a linear address.
- Adds single-shot/continuous modes, a frame-done pulse, abort handling and overflow flagging.
- Sits between the camera pins and the frame-buffer BRAM consumed by the colour-recognition logic.

Parameters:
- CLK_DIV, 5: i_Clk cycles per XCLK half-period; legal range is 1 or more.
- DATA_W, 8: sensor data bus width.
- BYTES_PER_PIXEL, 2: sensor bytes per pixel; legal values are 1 or 2.
- FRAME_W, 160: output pixels per line after decimation.
- FRAME_H, 120: output lines per frame after decimation.
- DECIM, 4: keep every DECIM-th input pixel and every DECIM-th input line, starting at index 0.
- ADDR_W, 15: RAM address width; must satisfy 2^ADDR_W >= FRAME_W*FRAME_H.

Ports:
- i_Clk  in  1  system clock; all logic on its rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_EnableCameraRead  in  1  arm capture (level).
- i_Single  in  1  1 = stop after one frame; 0 = continuous. Sampled when leaving IDLE.
- i_PLK  in  1  sensor pixel clock (asynchronous).
- i_VS  in  1  sensor VSYNC; high means vertical blanking.
- i_HS  in  1  sensor HREF; high means valid line data.
- i_D  in  DATA_W  sensor data, valid on i_PLK rising edge.
- o_XLK  out  1  generated sensor clock.
- o_to_RAM  out  DATA_W*BYTES_PER_PIXEL  pixel word; first byte received occupies the MSBs.
- o_RAM_Adress  out  ADDR_W  write address.
- o_RAM_Write_Enable  out  1  one-cycle write strobe.
- o_Frame_Done  out  1  one-cycle pulse at the end of a completed frame.
- o_Busy  out  1  high in WAIT_VS_LOW and CAPTURE.
- o_Overflow  out  1  sticky; cleared on reset or on leaving IDLE.

Behaviour:
- Reset values: o_XLK=0; o_to_RAM=0; o_RAM_Adress=0; o_RAM_Write_Enable=0; o_Frame_Done=0; o_Busy=0; o_Overflow=0; state=IDLE; all counters 0.
- XLK: a counter runs 0..CLK_DIV-1. o_XLK toggles when the counter wraps, giving a period of 2*CLK_DIV i_Clk cycles. It runs regardless of state.
- Synchronisation:
  - i_PLK, i_VS and i_HS each pass through 2 flops; PLK has a third flop for edge detection.
  - i_D is pipelined 2 flops so it stays aligned with synced PLK.
  - PLK rise = s2 & ~s3. VS rise/fall are detected the same way on synced VS. HS fall is detected on synced HS.
- FSM:
  - IDLE: when i_EnableCameraRead=1, latch i_Single, clear o_Overflow and go to WAIT_VS_LOW.
  - WAIT_VS_LOW: on synced VS fall, clear row/col/byte/address counters and go to CAPTURE.
  - CAPTURE:
    - Capture pixels on PLK rises while synced HS=1.
    - On synced VS rise: pulse o_Frame_Done. Go to IDLE if the latched single-shot bit is set, otherwise to WAIT_VS_LOW.
  - Abort: i_EnableCameraRead=0 in any non-IDLE state returns to IDLE next cycle. No o_Frame_Done, no further writes; o_RAM_Adress holds its value.
- Pixel assembly:
  - A byte phase counter runs 0..BYTES_PER_PIXEL-1 and shifts bytes into o_to_RAM's assembly register.
  - The byte phase resets on every HS fall; a partial pixel at line end is discarded.
  - The input column counter increments per completed pixel and resets on HS fall.
  - The input row counter increments on HS fall.
- Write rule: when a pixel completes, o_RAM_Write_Enable pulses for exactly 1 cycle if all of the following hold:
  - col%DECIM==0 and row%DECIM==0;
  - col/DECIM < FRAME_W and row/DECIM < FRAME_H.
- Write data and address:
  - o_to_RAM updates in the same cycle as the strobe.
  - o_RAM_Adress = (row/DECIM)*FRAME_W + col/DECIM, held stable during the strobe. Implement it as an incrementing counter; no multiplier is required.
- Latency: the strobe asserts 3 i_Clk edges after the raw i_PLK rise that carried the final byte.
- Overflow: a write that would exceed FRAME_W*FRAME_H-1 is suppressed and sets o_Overflow. Inputs beyond the window are simply dropped and do not set o_Overflow.
- Simultaneous events:
  - VS rise coinciding with a pixel completion: the pixel write is dropped and Frame_Done wins.
  - HS fall coinciding with a PLK rise: the byte is ignored.
- Reset mid-frame: all outputs return to their reset values immediately.

Test Plan:
- CLK_DIV=5, release reset -> o_XLK period is 10 i_Clk cycles and o_XLK=0 after reset.
- FRAME_W=4, FRAME_H=2, DECIM=1, single shot; 2 lines of 8 bytes 0x00..0x0F -> 8 writes at addresses 0..7 with data 0x0001, 0x0203, ... 0x0E0F, then one o_Frame_Done pulse and return to IDLE.
- DECIM=2, FRAME_W=2, FRAME_H=2; 4 lines of 4 pixels -> writes only for input lines 0 and 2 and pixels 0 and 2, at addresses 0,1,2,3.
- Continuous mode, 2 frames -> o_Frame_Done pulses twice and the second frame's addresses restart at 0.
- Deassert enable mid-line -> no further strobes, no o_Frame_Done, o_Busy=0 next cycle.
- Assert i_Rst_n=0 mid-capture -> all outputs 0 immediately. Then feed a frame with a 5-byte line (odd) -> the partial pixel is dropped and the next line starts at byte phase 0.
